// File: rtl/data_mask_pkg.sv
// Shared constants and state encoding for the data-mask memory controller.
package data_mask_pkg;

  localparam int DEPTH  = 40;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;
  localparam logic [WIDTH-1:0] CLEAR_VAL = 16'h0000;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/data_mask_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves on contention.
module data_mask_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       rr_ptr
);

  logic rr_ptr_r;

  // Grant decode: single requester wins outright, otherwise the pointer decides
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer register: flip to the loser after a contended grant
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= 1'b0;
    end else if (req == 2'b11) begin
      rr_ptr_r <= ~rr_ptr_r;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign rr_ptr = rr_ptr_r;

endmodule

// File: rtl/data_mask_ctrl.sv
// Clear sequencer, write arbiter wrapper and registered read path in front of
// a 40x16 1R1W data-mask macro.
module data_mask_ctrl
  import data_mask_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_req,
  output logic              busy,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [WIDTH-1:0]  wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [WIDTH-1:0]  wr1_data,
  output logic              wr_err,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [WIDTH-1:0]  mem_R0_data,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [WIDTH-1:0]  mem_W0_data
);

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] clear_cnt_r, clear_cnt_nxt_s;
  logic              run_s;
  logic [1:0]        req_s, gnt_s;
  logic              rr_ptr_s, sel_wr1_s;
  logic              win_vld_s, win_ok_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [WIDTH-1:0]  win_data_s;
  logic              rd_acc_s, rd_ok_s, bypass_s;
  logic              wr_err_r, resp_valid_r, resp_err_r;
  logic [WIDTH-1:0]  resp_data_r;

  assign run_s = (state_r == RUN);
  assign req_s = run_s ? {wr1_valid, wr0_valid} : 2'b00;

  data_mask_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req_s),
    .gnt    (gnt_s),
    .rr_ptr (rr_ptr_s)
  );

  // Winner select mirrors the arbiter's decision so the data mux follows the grant
  assign sel_wr1_s  = (req_s == 2'b11) ? rr_ptr_s : req_s[1];
  assign win_vld_s  = |gnt_s;
  assign win_addr_s = sel_wr1_s ? wr1_addr : wr0_addr;
  assign win_data_s = sel_wr1_s ? wr1_data : wr0_data;
  assign win_ok_s   = win_vld_s && (win_addr_s < ADDR_W'(DEPTH));

  assign rd_acc_s = run_s && rd_valid;
  assign rd_ok_s  = rd_addr < ADDR_W'(DEPTH);
  assign bypass_s = win_ok_s && (win_addr_s == rd_addr);

  // Next-state and clear counter sequencing
  always_comb begin
    state_nxt_s     = state_r;
    clear_cnt_nxt_s = clear_cnt_r;
    case (state_r)
      INIT, FLUSH: begin
        if (clear_cnt_r == ADDR_W'(DEPTH - 1)) begin
          state_nxt_s     = RUN;
          clear_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          clear_cnt_nxt_s = clear_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s     = INIT;
        clear_cnt_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Macro port drive: clear pattern while busy, arbitrated write / read in RUN
  always_comb begin
    if (run_s) begin
      mem_W0_en   = win_ok_s;
      mem_W0_addr = win_vld_s ? win_addr_s : {ADDR_W{1'b0}};
      mem_W0_data = win_vld_s ? win_data_s : {WIDTH{1'b0}};
      mem_R0_en   = rd_acc_s && rd_ok_s;
      mem_R0_addr = rd_addr;
    end else begin
      mem_W0_en   = 1'b1;
      mem_W0_addr = clear_cnt_r;
      mem_W0_data = CLEAR_VAL;
      mem_R0_en   = 1'b0;
      mem_R0_addr = {ADDR_W{1'b0}};
    end
  end

  // State, counter and registered response/error outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= INIT;
      clear_cnt_r  <= {ADDR_W{1'b0}};
      wr_err_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      clear_cnt_r  <= clear_cnt_nxt_s;
      wr_err_r     <= win_vld_s && !win_ok_s;
      resp_valid_r <= rd_acc_s;
      resp_err_r   <= rd_acc_s && !rd_ok_s;
      if (rd_acc_s && rd_ok_s) begin
        resp_data_r <= bypass_s ? win_data_s : mem_R0_data;
      end else begin
        resp_data_r <= {WIDTH{1'b0}};
      end
    end
  end

  assign busy       = !run_s;
  assign wr0_ready  = gnt_s[0];
  assign wr1_ready  = gnt_s[1];
  assign rd_ready   = run_s;
  assign wr_err     = wr_err_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_data_mask_ctrl.sv
// Directed and randomized bench for data_mask_ctrl with a behavioural macro
// and a reference memory model.
module tb_data_mask_ctrl;

  logic        clock, reset, flush_req, busy;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready, wr_err;
  logic [5:0]  wr0_addr, wr1_addr, rd_addr, mem_R0_addr, mem_W0_addr;
  logic [15:0] wr0_data, wr1_data, resp_data, mem_R0_data, mem_W0_data;
  logic        rd_valid, rd_ready, resp_valid, resp_err, mem_R0_en, mem_W0_en;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mac     [0:63];
  logic [15:0] ref_mem [0:39];
  int          exp_ptr;

  data_mask_ctrl dut (
    .clock(clock), .reset(reset), .flush_req(flush_req), .busy(busy),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr_err(wr_err), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: synchronous write, combinational read
  always @(posedge clock) if (mem_W0_en) mac[mem_W0_addr] <= mem_W0_data;
  assign mem_R0_data = mem_R0_en ? mac[mem_R0_addr] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0; flush_req = 1'b0;
    wr0_addr = 6'd0; wr1_addr = 6'd0; rd_addr = 6'd0;
    wr0_data = 16'h0; wr1_data = 16'h0;
  endtask

  // Expect a full clear pass starting now; ref_mem becomes all zero
  task automatic expect_clear(input string tag);
    for (int i = 0; i < 40; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_waddr"}, mem_W0_addr, i);
      chk({tag, "_wen"}, mem_W0_en, 1'b1);
      chk({tag, "_wdata"}, mem_W0_data, 16'h0000);
      chk({tag, "_rdy"}, {wr0_ready, wr1_ready, rd_ready, mem_R0_en}, 4'b0000);
      step();
    end
    chk({tag, "_done"}, busy, 1'b0);
    for (int i = 0; i < 40; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic do_read(input string tag, input logic [5:0] a);
    logic        e_err;
    logic [15:0] e_data;
    e_err  = (a >= 6'd40);
    e_data = e_err ? 16'h0000 : ref_mem[a];
    rd_valid = 1'b1; rd_addr = a;
    #1;
    chk({tag, "_rdy"}, rd_ready, 1'b1);
    chk({tag, "_ren"}, mem_R0_en, !e_err);
    step();
    rd_valid = 1'b0;
    chk({tag, "_rvld"}, resp_valid, 1'b1);
    chk({tag, "_rerr"}, resp_err, e_err);
    chk({tag, "_rdata"}, resp_data, e_data);
  endtask

  initial begin
    int          v0, v1, rv, g;
    logic [5:0]  a0, a1, ra, wa;
    logic [15:0] d0, d1, wd, e_data;
    logic        w_ok, e_err;

    for (int i = 0; i < 64; i++) mac[i] = 16'($urandom);
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 16'h0000);
    chk("rst_wr_err", wr_err, 1'b0);
    reset = 1'b0;
    exp_ptr = 0;
    expect_clear("init");
    do_read("rd0", 6'd0);
    do_read("rd39", 6'd39);

    // Contended writes to the same address alternate starting with requester 0
    wr0_valid = 1'b1; wr0_addr = 6'd3; wr0_data = 16'hAAAA;
    wr1_valid = 1'b1; wr1_addr = 6'd3; wr1_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", {wr1_ready, wr0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_wdata", mem_W0_data, (i % 2 == 0) ? 16'hAAAA : 16'h5555);
      step();
    end
    ref_mem[3] = 16'h5555;
    idle_inputs();
    do_read("rd3", 6'd3);

    // Same-cycle read and write to one address returns the new data
    wr0_valid = 1'b1; wr0_addr = 6'd5; wr0_data = 16'h1234;
    ref_mem[5] = 16'h1234;
    do_read("bypass", 6'd5);
    idle_inputs();
    do_read("rd5", 6'd5);

    // Out-of-range write and read
    wr1_valid = 1'b1; wr1_addr = 6'd45; wr1_data = 16'hDEAD;
    #1;
    chk("oor_gnt", wr1_ready, 1'b1);
    chk("oor_wen", mem_W0_en, 1'b0);
    step();
    idle_inputs();
    chk("oor_err", wr_err, 1'b1);
    step();
    chk("oor_err_clr", wr_err, 1'b0);
    do_read("rd63", 6'd63);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      v0 = int'($urandom_range(0, 1)); v1 = int'($urandom_range(0, 1));
      rv = int'($urandom_range(0, 1));
      a0 = 6'($urandom_range(0, 47)); a1 = 6'($urandom_range(0, 47));
      ra = 6'($urandom_range(0, 63));
      d0 = 16'($urandom); d1 = 16'($urandom);
      wr0_valid = v0[0]; wr0_addr = a0; wr0_data = d0;
      wr1_valid = v1[0]; wr1_addr = a1; wr1_data = d1;
      rd_valid = rv[0]; rd_addr = ra;
      #1;
      if (v0 == 1 && v1 == 1) begin
        g = exp_ptr; exp_ptr = 1 - exp_ptr;
      end else if (v0 == 1) g = 0;
      else if (v1 == 1) g = 1;
      else g = -1;
      chk("rnd_gnt0", wr0_ready, g == 0);
      chk("rnd_gnt1", wr1_ready, g == 1);
      wa = (g == 1) ? a1 : a0;
      wd = (g == 1) ? d1 : d0;
      w_ok = (g >= 0) && (wa < 6'd40);
      chk("rnd_wen", mem_W0_en, w_ok);
      if (w_ok) chk("rnd_wdata", {mem_W0_addr, mem_W0_data}, {wa, wd});
      e_err = (ra >= 6'd40);
      e_data = e_err ? 16'h0000 : ((w_ok && wa == ra) ? wd : ref_mem[ra]);
      step();
      if (w_ok) ref_mem[wa] = wd;
      chk("rnd_rvld", resp_valid, rv[0]);
      if (rv == 1) begin
        chk("rnd_rerr", resp_err, e_err);
        chk("rnd_rdata", resp_data, e_data);
      end
      chk("rnd_werr", wr_err, (g >= 0) && !w_ok);
    end
    idle_inputs();

    // Flush: the read in the flush_req cycle still answers, then a full clear
    wr0_valid = 1'b1; wr0_addr = 6'd10; wr0_data = 16'hBEEF;
    step();
    ref_mem[10] = 16'hBEEF;
    idle_inputs();
    flush_req = 1'b1;
    do_read("flush_rd", 6'd10);
    flush_req = 1'b0;
    wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1;
    expect_clear("flush");
    idle_inputs();
    do_read("rd10", 6'd10);

    // Reset in the middle of a flush restarts the clear from entry 0
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (20) step();
    chk("mid_cnt", mem_W0_addr, 6'd20);
    reset = 1'b1;
    step();
    chk("mid_rst_addr", mem_W0_addr, 6'd0);
    reset = 1'b0;
    expect_clear("rst_flush");
    exp_ptr = 0;
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    #1;
    chk("ptr_after_rst", {wr1_ready, wr0_ready}, 2'b01);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mask_ctrl.md
Name: data_mask_ctrl

Overview:
Controller and arbiter placed in front of one 40x16 1R1W data-mask memory macro; drives the macro's R0/W0 ports on a single clock domain.
After reset, and on each flush request, it clears every entry to CLEAR_VAL.
It then shares the single write port between two write requesters using round-robin arbitration, and serves one read requester with a registered response.

Parameters:
DEPTH, 40, number of valid memory entries
WIDTH, 16, data width
ADDR_W, 6, address width (must satisfy 2^ADDR_W >= DEPTH)
CLEAR_VAL, 16'h0000, value written to every entry during clear

Ports:
clock  in  1  single clock; also tied to the macro's R0_clk and W0_clk
reset  in  1  synchronous, active-high reset
flush_req  in  1  pulse; requests a full re-clear
busy  out  1  high while clearing (INIT or FLUSH)
wr0_valid  in  1  write request, requester 0
wr0_ready  out  1  grant to requester 0
wr0_addr  in  ADDR_W  write address, requester 0
wr0_data  in  WIDTH  write data, requester 0
wr1_valid  in  1  write request, requester 1
wr1_ready  out  1  grant to requester 1
wr1_addr  in  ADDR_W  write address, requester 1
wr1_data  in  WIDTH  write data, requester 1
wr_err  out  1  one-cycle pulse: a granted write had an out-of-range address
rd_valid  in  1  read request
rd_ready  out  1  read accept
rd_addr  in  ADDR_W  read address
resp_valid  out  1  read response valid; no backpressure
resp_data  out  WIDTH  read response data
resp_err  out  1  qualifies resp_valid: the read address was out of range
mem_R0_addr  out  ADDR_W  to macro R0_addr
mem_R0_en  out  1  to macro R0_en
mem_R0_data  in  WIDTH  from macro R0_data (combinational read)
mem_W0_addr  out  ADDR_W  to macro W0_addr
mem_W0_en  out  1  to macro W0_en
mem_W0_data  out  WIDTH  to macro W0_data

Behaviour:
- States (all transitions registered):
  - INIT: clear pass following reset.
  - RUN: normal operation.
  - FLUSH: clear pass following flush_req.
- Reset values: state=INIT, clear_cnt=0, rr_ptr=0 (requester 0 has priority), resp_valid=0, resp_data=0, resp_err=0, wr_err=0.
- Reset is honoured in any state, including mid-clear; the clear then restarts from entry 0.
- INIT/FLUSH:
  - Each cycle: mem_W0_en=1, mem_W0_addr=clear_cnt, mem_W0_data=CLEAR_VAL; clear_cnt increments.
  - The cycle that writes DEPTH-1 moves to RUN and resets clear_cnt. A clear therefore takes exactly DEPTH cycles.
  - busy=1; wr0_ready, wr1_ready, rd_ready and mem_R0_en are 0.
  - flush_req is ignored.
- RUN, write side:
  - Only one valid requester: it is granted (ready=1) in the same cycle, combinationally from valid.
  - Both valid: the requester selected by rr_ptr is granted, and rr_ptr flips to the other requester. rr_ptr is unchanged when there is no contention.
  - Grant drives mem_W0_* with the winner's addr/data. The write commits at the clock edge.
  - Granted address >= DEPTH: mem_W0_en=0, the write is dropped, and wr_err pulses on the next cycle.
- RUN, read side:
  - rd_ready=1 whenever in RUN.
  - On accept: mem_R0_en=1, mem_R0_addr=rd_addr. mem_R0_data is captured at the edge.
  - resp_valid goes high the following cycle, giving 1-cycle latency and up to 1 read per cycle.
  - Address >= DEPTH: mem_R0_en=0; the response has resp_data=0 and resp_err=1.
  - Bypass: if the accepted read and a granted in-range write target the same address in the same cycle, resp_data returns the write data.
  - Outside RUN, mem_R0_en=0 and mem_R0_addr=0.
- flush_req in RUN:
  - Writes and reads presented in that cycle are still served.
  - FLUSH is entered next cycle; a read accepted in that cycle still produces its response.
- No X is ever driven on outputs.

Decomposition:
- Package data_mask_pkg:
  - state enum {INIT, RUN, FLUSH};
  - DEPTH/WIDTH/ADDR_W constants;
  - CLEAR_VAL constant.
- Sub-module data_mask_rr_arb2: 2-requester round-robin arbiter with inputs req[1:0], clock and reset, and outputs gnt[1:0] plus the internal pointer.
- Everything else lives in data_mask_ctrl.

Test Plan:
- Reset released, no requests -> busy=1 for exactly 40 cycles; mem_W0_addr steps 0..39 with data 0; busy=0 at cycle 40; reads of addr 0 and 39 return 0.
- Both requesters valid for 4 cycles, wr0=(addr 3, 0xAAAA), wr1=(addr 3, 0x5555) -> grants alternate wr0, wr1, wr0, wr1; final read of addr 3 returns 0x5555.
- Read addr 5 in the same cycle as a granted write (addr 5, 0x1234) -> resp_valid next cycle with 0x1234; a later read of addr 5 also returns 0x1234.
- Write addr 45 -> mem_W0_en=0 and wr_err pulses once; read addr 63 -> resp_valid=1, resp_err=1, resp_data=0.
- Write (addr 10, 0xBEEF), then flush_req -> busy=1 for 40 cycles with all ready signals low; afterwards read addr 10 returns 0.
- Reset asserted at clear_cnt=20 during FLUSH -> clear restarts at 0 and busy lasts 40 cycles after reset deasserts.
